unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
- Moore FSM that drives every control input of the memory-game datapath (sequence/address counters, button and memory registers, display timer) and consumes its status flags.
- Sits directly upstream of the datapath.
- Runs a round: shows sequence positions 0..S on the display, one memory value per display-timer period, then collects S+1 button plays and compares each.
- Advances S until the last round, or ends on an error or a timeout.

Parameters:
- none (timer lengths live in the datapath counters)

Ports:
clock  input  1  system clock (1 kHz in the FPGA build)
reset  input  1  asynchronous, active-high; forces state inicial
iniciar  input  1  start/restart request, level-sampled
jogada_feita  input  1  one-cycle pulse: new button press
chavesIgualMemoria  input  1  registered play equals current memory word
enderecoIgualSequencia  input  1  address counter equals sequence counter
fimS  input  1  sequence counter at its last value (15)
fimTMR  input  1  display timer reached terminal count
timeout  input  1  no play within the timeout window
zeraR, zeraE, zeraS, zeraM, zeraTMR  output  1 each  clear button reg / address ctr / sequence ctr / memory reg / display timer
registraR, registraM  output  1 each  load button reg / memory reg
contaE, contaS, contaTMR  output  1 each  increment address / sequence / display timer
pronto  output  1  game finished
ganhou  output  1  finished with success
perdeu  output  1  finished by error or timeout
db_timeout  output  1  finished by timeout
db_estado  output  4  current state code

Behaviour:
- One state register, updated on the rising edge of clock.
- Asynchronous reset: state=inicial immediately, mid-operation included.
- Outputs are decoded from the state only (Moore); none depends combinationally on inputs.
- Unlisted outputs are 0 in each state.
- Reset values of all outputs: 0; db_estado=4'h0.
- States (code), asserted outputs, transitions:
  - inicial (0): iniciar -> preparacao.
  - preparacao (1): zeraR, zeraE, zeraS, zeraM, zeraTMR. Next: inicio_rodada.
  - inicio_rodada (2): zeraE, zeraTMR. Next: le_memoria.
  - le_memoria (3): none. This is the one-cycle wait for the synchronous ROM. Next: carrega_dado.
  - carrega_dado (4): registraM. Next: exibe.
  - exibe (5): contaTMR. On fimTMR: if enderecoIgualSequencia -> fim_exibe, else -> proximo_exibe. Otherwise stay.
  - proximo_exibe (6): contaE, zeraTMR. Next: le_memoria.
  - fim_exibe (7): zeraE, zeraM, zeraTMR. This also restarts the datapath timeout counter. Next: espera_jogada.
  - espera_jogada (8): none.
    - jogada_feita -> registra. If jogada_feita and timeout arrive together, jogada_feita wins.
    - Otherwise timeout -> fim_timeout.
    - Otherwise stay.
  - registra (9): registraR. Next: compara.
  - compara (A): evaluated in this priority order:
    - !chavesIgualMemoria -> fim_errou
    - else !enderecoIgualSequencia -> proxima_jogada
    - else fimS -> fim_acertou
    - else -> proxima_rodada
  - proxima_jogada (B): contaE. Next: espera_jogada.
  - proxima_rodada (C): contaS. Next: inicio_rodada.
  - fim_acertou (D): pronto, ganhou.
  - fim_errou (E): pronto, perdeu.
  - fim_timeout (F): pronto, perdeu, db_timeout.
- Terminal states hold until iniciar, then -> preparacao.
- iniciar is ignored in every other state.
- A jogada_feita pulse outside espera_jogada is ignored; it is not queued.
- Timing:
  - Minimum display period per word = 500 exibe cycles + 3 overhead cycles.
  - Play latency from jogada_feita to compara = 2 cycles.
- The FSM never asserts contaS and zeraS together. No invalid code is reachable; the default branch goes to inicial.

Decomposition:
- Shared package (jogo_pkg) holds:
  - the 4-bit state localparams (inicial..fim_timeout), used by this block and by the 7-segment state decoder for db_estado;
  - the timer constants M_TMR=500 and M_TIMEOUT=5000 so the bench and datapath agree.
- No sub-module is needed: next-state and output decode are two always blocks in one module.

Test Plan:
1. reset=1 mid-exibe -> state 0 and all outputs 0 in the same cycle, without waiting for a clock edge; after reset=0 the FSM stays in 0 until iniciar.
2. iniciar one cycle -> sequence 0,1,2,3,4,5. Hold fimTMR=0 for 499 cycles, then pulse fimTMR with enderecoIgualSequencia=1 -> 7 then 8; registraM is asserted exactly one cycle, in state 4.
3. In 8, pulse jogada_feita with chavesIgualMemoria=1, enderecoIgualSequencia=0 -> 9, A, B, back to 8; contaE is high exactly one cycle.
4. In A, drive chavesIgualMemoria=0 -> E; pronto=1, perdeu=1, ganhou=0; then iniciar -> 1.
5. In 8, assert timeout with no jogada_feita -> F; db_timeout=1, perdeu=1. Separately, assert timeout and jogada_feita in the same cycle -> 9.
6. In A, drive chavesIgualMemoria=1, enderecoIgualSequencia=1, fimS=0 -> C, then 2 with contaS pulsed once. Repeat with fimS=1 -> D; ganhou=1, pronto=1.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control unit and its datapath:
// state codes, timer lengths and the per-state control word.
package jogo_pkg;

  // 4-bit state codes, also decoded by the 7-segment state display
  localparam logic [3:0] ST_INICIAL        = 4'h0;
  localparam logic [3:0] ST_PREPARACAO     = 4'h1;
  localparam logic [3:0] ST_INICIO_RODADA  = 4'h2;
  localparam logic [3:0] ST_LE_MEMORIA     = 4'h3;
  localparam logic [3:0] ST_CARREGA_DADO   = 4'h4;
  localparam logic [3:0] ST_EXIBE          = 4'h5;
  localparam logic [3:0] ST_PROXIMO_EXIBE  = 4'h6;
  localparam logic [3:0] ST_FIM_EXIBE      = 4'h7;
  localparam logic [3:0] ST_ESPERA_JOGADA  = 4'h8;
  localparam logic [3:0] ST_REGISTRA       = 4'h9;
  localparam logic [3:0] ST_COMPARA        = 4'hA;
  localparam logic [3:0] ST_PROXIMA_JOGADA = 4'hB;
  localparam logic [3:0] ST_PROXIMA_RODADA = 4'hC;
  localparam logic [3:0] ST_FIM_ACERTOU    = 4'hD;
  localparam logic [3:0] ST_FIM_ERROU      = 4'hE;
  localparam logic [3:0] ST_FIM_TIMEOUT    = 4'hF;

  // Timer lengths in clock cycles, shared by the datapath counters
  localparam int M_TMR     = 500;
  localparam int M_TIMEOUT = 5000;

  typedef enum logic [3:0] {
    inicial        = ST_INICIAL,
    preparacao     = ST_PREPARACAO,
    inicio_rodada  = ST_INICIO_RODADA,
    le_memoria     = ST_LE_MEMORIA,
    carrega_dado   = ST_CARREGA_DADO,
    exibe          = ST_EXIBE,
    proximo_exibe  = ST_PROXIMO_EXIBE,
    fim_exibe      = ST_FIM_EXIBE,
    espera_jogada  = ST_ESPERA_JOGADA,
    registra       = ST_REGISTRA,
    compara        = ST_COMPARA,
    proxima_jogada = ST_PROXIMA_JOGADA,
    proxima_rodada = ST_PROXIMA_RODADA,
    fim_acertou    = ST_FIM_ACERTOU,
    fim_errou      = ST_FIM_ERROU,
    fim_timeout    = ST_FIM_TIMEOUT
  } estado_t;

  // Everything the control unit drives into the datapath and status outputs
  typedef struct packed {
    logic zera_r;
    logic zera_e;
    logic zera_s;
    logic zera_m;
    logic zera_tmr;
    logic registra_r;
    logic registra_m;
    logic conta_e;
    logic conta_s;
    logic conta_tmr;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic db_timeout;
  } controle_t;

  // Moore output table: the control word depends on the state alone
  function automatic controle_t decodifica_controle(input estado_t estado);
    controle_t c;
    c = '0;
    case (estado)
      preparacao: begin
        c.zera_r   = 1'b1;
        c.zera_e   = 1'b1;
        c.zera_s   = 1'b1;
        c.zera_m   = 1'b1;
        c.zera_tmr = 1'b1;
      end
      inicio_rodada: begin
        c.zera_e   = 1'b1;
        c.zera_tmr = 1'b1;
      end
      carrega_dado:   c.registra_m = 1'b1;
      exibe:          c.conta_tmr  = 1'b1;
      proximo_exibe: begin
        c.conta_e  = 1'b1;
        c.zera_tmr = 1'b1;
      end
      // Clearing the memory register here also restarts the timeout counter
      fim_exibe: begin
        c.zera_e   = 1'b1;
        c.zera_m   = 1'b1;
        c.zera_tmr = 1'b1;
      end
      registra:       c.registra_r = 1'b1;
      proxima_jogada: c.conta_e    = 1'b1;
      proxima_rodada: c.conta_s    = 1'b1;
      fim_acertou: begin
        c.pronto = 1'b1;
        c.ganhou = 1'b1;
      end
      fim_errou: begin
        c.pronto = 1'b1;
        c.perdeu = 1'b1;
      end
      fim_timeout: begin
        c.pronto     = 1'b1;
        c.perdeu     = 1'b1;
        c.db_timeout = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Bundle between the game control unit (master) and the datapath plus
// player/status side (slave).
interface unidade_controle_jogo_if;

  // Requests and datapath status flags
  logic iniciar;
  logic jogada_feita;
  logic chavesIgualMemoria;
  logic enderecoIgualSequencia;
  logic fimS;
  logic fimTMR;
  logic timeout;

  // Datapath control strobes
  logic zeraR;
  logic zeraE;
  logic zeraS;
  logic zeraM;
  logic zeraTMR;
  logic registraR;
  logic registraM;
  logic contaE;
  logic contaS;
  logic contaTMR;

  // Game result and debug
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       db_timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia,
           fimS, fimTMR, timeout,
    output zeraR, zeraE, zeraS, zeraM, zeraTMR, registraR, registraM,
           contaE, contaS, contaTMR, pronto, ganhou, perdeu, db_timeout,
           db_estado
  );

  modport slave (
    output iniciar, jogada_feita, chavesIgualMemoria, enderecoIgualSequencia,
           fimS, fimTMR, timeout,
    input  zeraR, zeraE, zeraS, zeraM, zeraTMR, registraR, registraM,
           contaE, contaS, contaTMR, pronto, ganhou, perdeu, db_timeout,
           db_estado
  );

endinterface

// File: rtl/unidade_controle_jogo.sv
// Moore control unit of the memory game: shows the sequence of the current
// round, collects and checks the player's moves, and reports the result.
module unidade_controle_jogo
  import jogo_pkg::*;
(
  input logic                    clock,
  input logic                    reset,
  unidade_controle_jogo_if.master bus
);

  estado_t   estado_atual;
  estado_t   proximo_estado;
  controle_t controle;

  // State register; reset drops straight back to inicial
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado_atual <= inicial;
    else
      estado_atual <= proximo_estado;
  end

  // Next-state logic; requests arriving in states that do not look at them are dropped
  always_comb begin
    proximo_estado = estado_atual;
    case (estado_atual)
      inicial:        if (bus.iniciar) proximo_estado = preparacao;
      preparacao:     proximo_estado = inicio_rodada;
      inicio_rodada:  proximo_estado = le_memoria;
      le_memoria:     proximo_estado = carrega_dado;
      carrega_dado:   proximo_estado = exibe;
      exibe: begin
        if (bus.fimTMR)
          proximo_estado = bus.enderecoIgualSequencia ? fim_exibe : proximo_exibe;
      end
      proximo_exibe:  proximo_estado = le_memoria;
      fim_exibe:      proximo_estado = espera_jogada;
      espera_jogada: begin
        if (bus.jogada_feita)
          proximo_estado = registra;
        else if (bus.timeout)
          proximo_estado = fim_timeout;
      end
      registra:       proximo_estado = compara;
      compara: begin
        if (!bus.chavesIgualMemoria)
          proximo_estado = fim_errou;
        else if (!bus.enderecoIgualSequencia)
          proximo_estado = proxima_jogada;
        else if (bus.fimS)
          proximo_estado = fim_acertou;
        else
          proximo_estado = proxima_rodada;
      end
      proxima_jogada: proximo_estado = espera_jogada;
      proxima_rodada: proximo_estado = inicio_rodada;
      fim_acertou, fim_errou, fim_timeout: begin
        if (bus.iniciar) proximo_estado = preparacao;
      end
      default:        proximo_estado = inicial;
    endcase
  end

  // Output decode from the current state only
  always_comb begin
    controle = decodifica_controle(estado_atual);
  end

  assign bus.zeraR      = controle.zera_r;
  assign bus.zeraE      = controle.zera_e;
  assign bus.zeraS      = controle.zera_s;
  assign bus.zeraM      = controle.zera_m;
  assign bus.zeraTMR    = controle.zera_tmr;
  assign bus.registraR  = controle.registra_r;
  assign bus.registraM  = controle.registra_m;
  assign bus.contaE     = controle.conta_e;
  assign bus.contaS     = controle.conta_s;
  assign bus.contaTMR   = controle.conta_tmr;
  assign bus.pronto     = controle.pronto;
  assign bus.ganhou     = controle.ganhou;
  assign bus.perdeu     = controle.perdeu;
  assign bus.db_timeout = controle.db_timeout;
  assign bus.db_estado  = estado_atual;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for the game control unit: each step drives the inputs,
// queues the state and output word it should produce, then checks them
// one clock later.
module tb_unidade_controle_jogo;

  // Input pattern bits: {iniciar, jogada_feita, chaves, endereco, fimS, fimTMR, timeout}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_INI  = 7'b1000000;
  localparam logic [6:0] I_JOG  = 7'b0100000;
  localparam logic [6:0] I_CHV  = 7'b0010000;
  localparam logic [6:0] I_END  = 7'b0001000;
  localparam logic [6:0] I_FS   = 7'b0000100;
  localparam logic [6:0] I_FT   = 7'b0000010;
  localparam logic [6:0] I_TO   = 7'b0000001;

  typedef struct {
    string      tag;
    logic [3:0] estado;
    logic [13:0] saidas;
  } esperado_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   reg_m_count;
  int   conta_e_count;
  int   conta_s_count;
  esperado_t scoreboard[$];

  unidade_controle_jogo_if intf();

  unidade_controle_jogo dut (
    .clock(clock),
    .reset(reset),
    .bus  (intf.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected control word per state, written out from the state table
  function automatic logic [13:0] saidas_esperadas(input logic [3:0] estado);
    case (estado)
      4'h1:    return 14'b11111000000000;
      4'h2:    return 14'b01001000000000;
      4'h4:    return 14'b00000010000000;
      4'h5:    return 14'b00000000010000;
      4'h6:    return 14'b00001001000000;
      4'h7:    return 14'b01011000000000;
      4'h9:    return 14'b00000100000000;
      4'hB:    return 14'b00000001000000;
      4'hC:    return 14'b00000000100000;
      4'hD:    return 14'b00000000001100;
      4'hE:    return 14'b00000000001010;
      4'hF:    return 14'b00000000001011;
      default: return 14'b00000000000000;
    endcase
  endfunction

  function automatic logic [13:0] saidas_observadas();
    return {intf.zeraR, intf.zeraE, intf.zeraS, intf.zeraM, intf.zeraTMR,
            intf.registraR, intf.registraM, intf.contaE, intf.contaS,
            intf.contaTMR, intf.pronto, intf.ganhou, intf.perdeu,
            intf.db_timeout};
  endfunction

  task automatic drive_inputs(input logic [6:0] v);
    intf.iniciar                = v[6];
    intf.jogada_feita           = v[5];
    intf.chavesIgualMemoria     = v[4];
    intf.enderecoIgualSequencia = v[3];
    intf.fimS                   = v[2];
    intf.fimTMR                 = v[1];
    intf.timeout                = v[0];
  endtask

  task automatic push_expected(input string tag, input logic [3:0] estado);
    esperado_t e;
    e.tag    = tag;
    e.estado = estado;
    e.saidas = saidas_esperadas(estado);
    scoreboard.push_back(e);
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic check_output();
    esperado_t   e;
    logic [13:0] obs;
    if (scoreboard.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e   = scoreboard.pop_front();
    obs = saidas_observadas();
    check_value({e.tag, "_estado"}, {28'd0, intf.db_estado}, {28'd0, e.estado});
    check_value({e.tag, "_saidas"}, {18'd0, obs}, {18'd0, e.saidas});
    if (intf.registraM === 1'b1) reg_m_count++;
    if (intf.contaE === 1'b1) conta_e_count++;
    if (intf.contaS === 1'b1) conta_s_count++;
  endtask

  // One clock: drive inputs, queue the expected state, sample 1 after the edge
  task automatic apply_stimulus(input logic [6:0] v, input logic [3:0] estado,
                                input string tag);
    drive_inputs(v);
    push_expected(tag, estado);
    @(posedge clock);
    #1;
    check_output();
  endtask

  // Walk from preparacao to espera_jogada with a one-word display
  task automatic to_espera(input string tag);
    apply_stimulus(I_NONE, 4'h2, tag);
    apply_stimulus(I_NONE, 4'h3, tag);
    apply_stimulus(I_NONE, 4'h4, tag);
    apply_stimulus(I_NONE, 4'h5, tag);
    apply_stimulus(I_FT | I_END, 4'h7, tag);
    apply_stimulus(I_NONE, 4'h8, tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reg_m_count   = 0;
    conta_e_count = 0;
    conta_s_count = 0;
    reset = 1'b1;
    drive_inputs(I_NONE);
    #12;
    push_expected("reset_inicial", 4'h0);
    check_output();
    reset = 1'b0;

    apply_stimulus(I_NONE, 4'h0, "idle");
    apply_stimulus(I_INI, 4'h1, "start");
    apply_stimulus(I_NONE, 4'h2, "inicio_rodada");
    apply_stimulus(I_NONE, 4'h3, "le_memoria");
    apply_stimulus(I_NONE, 4'h4, "carrega");
    apply_stimulus(I_NONE, 4'h5, "exibe");
    apply_stimulus(I_NONE, 4'h5, "exibe_hold");

    // Asynchronous reset mid-display, checked between clock edges
    drive_inputs(I_NONE);
    #3;
    reset = 1'b1;
    #1;
    push_expected("reset_async", 4'h0);
    check_output();
    #2;
    reset = 1'b0;
    apply_stimulus(I_NONE, 4'h0, "after_reset");
    apply_stimulus(I_JOG | I_END, 4'h0, "after_reset_noini");

    // Full display period: 499 cycles without fimTMR, then terminal count
    reg_m_count = 0;
    apply_stimulus(I_INI, 4'h1, "start2");
    apply_stimulus(I_NONE, 4'h2, "inicio2");
    apply_stimulus(I_NONE, 4'h3, "le2");
    apply_stimulus(I_NONE, 4'h4, "carrega2");
    for (int i = 0; i < 499; i++)
      apply_stimulus(I_JOG, 4'h5, "exibe_wait");
    apply_stimulus(I_FT | I_END, 4'h7, "fim_exibe");
    apply_stimulus(I_INI, 4'h8, "espera");
    check_value("registraM_one_cycle", reg_m_count, 1);

    // Correct play, more plays pending in this round
    conta_e_count = 0;
    apply_stimulus(I_JOG | I_CHV, 4'h9, "registra");
    apply_stimulus(I_CHV, 4'hA, "compara");
    apply_stimulus(I_CHV, 4'hB, "proxima_jogada");
    apply_stimulus(I_NONE, 4'h8, "back_espera");
    check_value("contaE_one_cycle", conta_e_count, 1);

    // Wrong play ends the game
    apply_stimulus(I_JOG, 4'h9, "registra_err");
    apply_stimulus(I_NONE, 4'hA, "compara_err");
    apply_stimulus(I_END | I_FS, 4'hE, "fim_errou");
    apply_stimulus(I_NONE, 4'hE, "fim_errou_hold");
    apply_stimulus(I_INI, 4'h1, "restart_err");

    // Display with two words, then timeout while waiting
    apply_stimulus(I_NONE, 4'h2, "r_inicio");
    apply_stimulus(I_NONE, 4'h3, "r_le");
    apply_stimulus(I_NONE, 4'h4, "r_carrega");
    apply_stimulus(I_NONE, 4'h5, "r_exibe");
    apply_stimulus(I_FT, 4'h6, "proximo_exibe");
    apply_stimulus(I_NONE, 4'h3, "r_le2");
    apply_stimulus(I_NONE, 4'h4, "r_carrega2");
    apply_stimulus(I_NONE, 4'h5, "r_exibe2");
    apply_stimulus(I_FT | I_END, 4'h7, "r_fim_exibe");
    apply_stimulus(I_NONE, 4'h8, "r_espera");
    apply_stimulus(I_TO, 4'hF, "fim_timeout");
    apply_stimulus(I_NONE, 4'hF, "fim_timeout_hold");
    apply_stimulus(I_INI, 4'h1, "restart_to");

    // Play and timeout together: the play wins; then a round advance
    to_espera("t_path");
    apply_stimulus(I_TO | I_JOG, 4'h9, "play_beats_timeout");
    apply_stimulus(I_NONE, 4'hA, "t_compara");
    conta_s_count = 0;
    apply_stimulus(I_CHV | I_END, 4'hC, "proxima_rodada");
    apply_stimulus(I_NONE, 4'h2, "next_round");
    check_value("contaS_one_cycle", conta_s_count, 1);

    // Last round completed correctly
    apply_stimulus(I_NONE, 4'h3, "w_le");
    apply_stimulus(I_NONE, 4'h4, "w_carrega");
    apply_stimulus(I_NONE, 4'h5, "w_exibe");
    apply_stimulus(I_FT | I_END, 4'h7, "w_fim_exibe");
    apply_stimulus(I_NONE, 4'h8, "w_espera");
    apply_stimulus(I_JOG, 4'h9, "w_registra");
    apply_stimulus(I_NONE, 4'hA, "w_compara");
    apply_stimulus(I_CHV | I_END | I_FS, 4'hD, "fim_acertou");
    apply_stimulus(I_NONE, 4'hD, "fim_acertou_hold");
    apply_stimulus(I_INI, 4'h1, "restart_win");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
